// File: rtl/mem_access_unit.sv
// Load/store front end for a big-endian, word-wide data memory: word-aligned accesses only,
// sub-word stores by read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned half/word requests.
module mem_access_unit #(
    parameter int MEM_READ_LAT = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int CNT_W = (MEM_READ_LAT > 1) ? $clog2(MEM_READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_READ_LAT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic             r_sign;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic [15:0]      r_wdata;
    logic             w_err;
    logic [1:0]       w_off;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[31-8*off -: 8];
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = {{24{sign & b[7]}}, b};
            2'b01:   r = {{16{sign & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)
            r[31-8*off -: 8] = wd[7:0];
        else if (off[1])
            r[15:0] = wd;
        else
            r[31:16] = wd;
        return r;
    endfunction

    // Misaligned half/word either trap or are silently aligned via the lane offset.
`ifdef MISALIGN_TRAP_EN
    assign w_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign w_err = (req_size == 2'b11);
`endif
    assign w_off = (req_size == 2'b00) ? req_addr[1:0] :
                   (req_size == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_write        <= 1'b0;
            r_sign         <= 1'b0;
            r_size         <= 2'b00;
            r_off          <= 2'b00;
            r_wdata        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_sign      <= req_sign;
                        r_size      <= req_size;
                        r_off       <= w_off;
                        r_wdata     <= req_wdata[15:0];
                        r_cnt       <= '0;
                        req_ready   <= 1'b0;
                        mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (w_err) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write || req_size != 2'b10) begin
                            r_state  <= RD;
                            mem_read <= 1'b1;
                        end else begin
                            r_state        <= WR;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (r_cnt == CNT_LAST) begin
                        mem_read <= 1'b0;
                        if (r_write) begin
                            r_state        <= WR;
                            mem_write      <= 1'b1;
                            mem_write_data <= lane_merge(mem_read_data, r_wdata, r_size, r_off);
                        end else begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= lane_extract(mem_read_data, r_size, r_off, r_sign);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR: begin
                    r_state    <= RESP;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    r_state    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, directed test-plan cases, reset abort, random traffic.
module tb_mem_access_unit;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    mem_access_unit #(.MEM_READ_LAT(L), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // DataMemory stand-in (written only by the DUT) and the reference byte image.
    logic [31:0] dmem [64];
    logic [7:0]  refb [256];
    assign mem_read_data = dmem[mem_address[7:2]];
    always @(posedge clk) if (mem_write) dmem[mem_address[7:2]] <= mem_write_data;

    int ncmp = 0;
    int nerr = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;
    logic [31:0] exp_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w], refb[4*w+1], refb[4*w+2], refb[4*w+3]};
    endfunction

    // Monitor: every active memory cycle must be exclusive and target the expected aligned word.
    always @(negedge clk) begin
        if (reset_n && (mem_read || mem_write)) begin
            chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
            chk("mem_address", mem_address, exp_addr);
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
        end
    end

    // Reference: compute response, latency and access counts from byte-level rules.
    task automatic model(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output int lat, output int nrd, output int nwr, output int ea);
        int n;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3);
`ifdef MISALIGN_TRAP_EN
        if (sz != 2'd3 && (int'(a) % n) != 0) err = 1'b1;
`endif
        ea = int'(a) - (int'(a) % n);
        rd = '0; lat = 1; nrd = 0; nwr = 0;
        if (err) return;
        if (!wr) begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(refb[ea+i]);
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v; lat = L + 1; nrd = L;
        end else begin
            for (int i = 0; i < n; i++) refb[ea+i] = 8'(wd >> (8*(n-1-i)));
            lat = (n == 4) ? 2 : L + 2; nrd = (n == 4) ? 0 : L; nwr = 1;
        end
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                          input logic [31:0] wd, input bit use_lit, input logic [31:0] lit);
        bit e_err; logic [31:0] e_rd; int e_lat, e_nrd, e_nwr, ea, cyc, rd0, wr0;
        bit got;
        model(wr, sz, sg, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, ea);
        exp_addr = 32'(ea - ea % 4);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_sign = sg;
        req_addr = 32'(a); req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready) got = 1'b1; else @(negedge clk);
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        rd0 = rd_cyc; wr0 = wr_cyc;
        #1 req_valid = 1'b0;
        got = 1'b0; cyc = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); cyc++;
            if (resp_valid) got = 1'b1;
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_rdata", resp_rdata, e_rd);
        if (use_lit) chk("rdata_literal", resp_rdata, lit);
        chk("mem_read_cycles", 32'(rd_cyc - rd0), 32'(e_nrd));
        chk("mem_write_pulses", 32'(wr_cyc - wr0), 32'(e_nwr));
        if (wr && !e_err) chk("stored_word", dmem[ea/4], ref_word(ea/4));
    endtask

    initial begin
        bit wr; logic [1:0] sz; int wr_before;
        for (int i = 0; i < 256; i++) refb[i] = 8'($urandom);
        refb[16] = 8'h88; refb[17] = 8'h99; refb[18] = 8'hAA; refb[19] = 8'hBB;
        for (int w = 0; w < 64; w++) dmem[w] = ref_word(w);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        reset_n = 1'b1;

        do_req(0, 2'd0, 1, 8'h11, 32'h0, 1, 32'hFFFF_FF99);
        do_req(0, 2'd1, 0, 8'h12, 32'h0, 1, 32'h0000_AABB);
        do_req(0, 2'd2, 0, 8'h10, 32'h0, 1, 32'h8899_AABB);
        do_req(1, 2'd0, 0, 8'h13, 32'h0000_0055, 1, 32'h0);
        chk("rmw_word_literal", dmem[4], 32'h8899_AA55);
        do_req(0, 2'd2, 0, 8'h10, 32'h0, 1, 32'h8899_AA55);
        do_req(1, 2'd2, 0, 8'h04, 32'h0123_4567, 1, 32'h0);
        do_req(0, 2'd0, 0, 8'h04, 32'h0, 1, 32'h0000_0001);
`ifdef MISALIGN_TRAP_EN
        do_req(0, 2'd2, 0, 8'h06, 32'h0, 1, 32'h0);
`else
        do_req(0, 2'd2, 0, 8'h06, 32'h0, 1, 32'h0123_4567);
`endif
        do_req(0, 2'd3, 1, 8'h20, 32'h0, 1, 32'h0);
        do_req(1, 2'd1, 0, 8'h22, 32'hDEAD_BEEF, 0, 32'h0);

        // Reset while a sub-word store is still reading: no write may follow.
        exp_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hA5;
        @(posedge clk);
        wr_before = wr_cyc;
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_rd", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 32'(wr_cyc - wr_before), 32'd0);
        chk("abort_mem_intact", dmem[8], ref_word(8));

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(wr, sz, 1'($urandom), 8'($urandom), $urandom, 0, 32'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int w = 0; w < 64; w++) chk("final_image", dmem[w], ref_word(w));

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
